// File: rtl/nvdla_glb_intr_csb.sv
// Global CSB register slave (version/mask/set/W1C status) plus sticky done-pulse interrupt aggregator.
// Request in T -> response in T+2 (reads, nposted writes); prdy tied high. Optional error response: NVDLA_GLB_CSB_ERR_RESP_EN.
module nvdla_glb_intr_csb #(
  parameter int unsigned NUM_SRC    = 8,
  parameter logic [11:0] BASE_WADDR = 12'h000,
  parameter logic [31:0] HW_VERSION = 32'h0002_0000,
  parameter logic [31:0] MASK_RST   = {32{1'b1}},
  localparam int unsigned SW        = 2 * NUM_SRC
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          csb2glb_req_pvld,
  output logic          csb2glb_req_prdy,
  input  logic [62:0]   csb2glb_req_pd,
  output logic          glb2csb_resp_valid,
  output logic [33:0]   glb2csb_resp_pd,
  input  logic [SW-1:0] done_pulse,
  output logic [SW-1:0] done_mask,
  output logic          core_intr
);

  localparam logic [9:0] W_VER  = 10'd0;
  localparam logic [9:0] W_MASK = 10'd1;
  localparam logic [9:0] W_SET  = 10'd2;
  localparam logic [9:0] W_STAT = 10'd3;

  logic          r_req_vld;
  logic [62:0]   r_req_pd;
  logic [SW-1:0] r_mask;
  logic [SW-1:0] r_status;
  logic          r_intr;
  logic          r_resp_vld;
  logic [33:0]   r_resp_pd;

  logic [21:0]   w_addr;
  logic [31:0]   w_wdat;
  logic          w_wr;
  logic          w_nposted;
  logic [3:0]    w_wrbe;
  logic [9:0]    w_word;
  logic          w_hit;
  logic          w_known;
  logic          w_wr_en;
  logic          w_mask_we;
  logic          w_set_we;
  logic          w_w1c_we;
  logic [31:0]   w_mask_ext;
  logic [31:0]   w_status_ext;
  logic [31:0]   w_mask_lane;
  logic [SW-1:0] w_mask_next;
  logic [SW-1:0] w_set;
  logic [SW-1:0] w_w1c;
  logic [SW-1:0] w_status_next;
  logic [31:0]   w_rdata;
  logic          w_err;
  logic          w_resp_fire;
  logic          w_unused;

  assign csb2glb_req_prdy = 1'b1;

  // Stage 1: capture the request; payload is only meaningful alongside r_req_vld.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_req_vld <= 1'b0;
    end else begin
      r_req_vld <= csb2glb_req_pvld;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (csb2glb_req_pvld) begin
      r_req_pd <= csb2glb_req_pd;
    end
  end

  assign w_addr    = r_req_pd[21:0];
  assign w_wdat    = r_req_pd[53:22];
  assign w_wr      = r_req_pd[54];
  assign w_nposted = r_req_pd[55];
  assign w_wrbe    = r_req_pd[60:57];
  assign w_unused  = ^{r_req_pd[62:61], r_req_pd[56]};

  assign w_word  = w_addr[9:0];
  assign w_hit   = (w_addr[21:10] == BASE_WADDR);
  assign w_known = w_hit && (w_word < 10'd4);
  assign w_wr_en = r_req_vld && w_wr && w_hit;

  assign w_mask_we = w_wr_en && (w_word == W_MASK);
  assign w_set_we  = w_wr_en && (w_word == W_SET);
  assign w_w1c_we  = w_wr_en && (w_word == W_STAT);

  // Zero-extend to the 32-bit register view so bits >= SW read 0 and drop writes.
  always_comb begin
    w_mask_ext             = '0;
    w_mask_ext[SW-1:0]     = r_mask;
    w_status_ext           = '0;
    w_status_ext[SW-1:0]   = r_status;
    w_mask_lane            = w_mask_ext;
    for (int k = 0; k < 4; k++) begin
      if (w_wrbe[k]) begin
        w_mask_lane[8*k +: 8] = w_wdat[8*k +: 8];
      end
    end
  end

  assign w_mask_next   = w_mask_we ? w_mask_lane[SW-1:0] : r_mask;
  assign w_set         = w_set_we ? w_wdat[SW-1:0] : '0;
  assign w_w1c         = w_w1c_we ? w_wdat[SW-1:0] : '0;
  // Pulses and SET are ORed in after the clear, so a set wins over a same-cycle W1C.
  assign w_status_next = (r_status & ~w_w1c) | done_pulse | w_set;

  always_comb begin
    w_rdata = '0;
    if (w_known && !w_wr) begin
      case (w_word)
        W_VER:   w_rdata = HW_VERSION;
        W_MASK:  w_rdata = w_mask_ext;
        W_STAT:  w_rdata = w_status_ext;
        default: w_rdata = '0;
      endcase
    end
  end

`ifdef NVDLA_GLB_CSB_ERR_RESP_EN
  assign w_err = !w_known;
`else
  assign w_err = 1'b0;
`endif

  assign w_resp_fire = r_req_vld && (!w_wr || w_nposted);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_mask   <= MASK_RST[SW-1:0];
      r_status <= '0;
      r_intr   <= 1'b0;
    end else begin
      r_mask   <= w_mask_next;
      r_status <= w_status_next;
      r_intr   <= |(w_status_next & ~w_mask_next);
    end
  end

  // Stage 2: registered response; pd holds its last value between responses.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_resp_vld <= 1'b0;
      r_resp_pd  <= '0;
    end else begin
      r_resp_vld <= w_resp_fire;
      if (w_resp_fire) begin
        r_resp_pd <= {w_wr, w_err, w_rdata};
      end
    end
  end

  assign glb2csb_resp_valid = r_resp_vld;
  assign glb2csb_resp_pd    = r_resp_pd;
  assign done_mask          = r_mask;
  assign core_intr          = r_intr;

endmodule

// File: tb/tb_nvdla_glb_intr_csb.sv
// Randomised + directed bench for nvdla_glb_intr_csb (NUM_SRC=8) against a transaction-level register model.
module tb_nvdla_glb_intr_csb;

  localparam int SW = 16;
`ifdef NVDLA_GLB_CSB_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          pvld;
  logic          prdy;
  logic [62:0]   req_pd;
  logic          resp_valid;
  logic [33:0]   resp_pd;
  logic [SW-1:0] pulse;
  logic [SW-1:0] mask_o;
  logic          intr;

  always #5 clk = ~clk;

  nvdla_glb_intr_csb dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rstn    (rstn),
    .csb2glb_req_pvld   (pvld),
    .csb2glb_req_prdy   (prdy),
    .csb2glb_req_pd     (req_pd),
    .glb2csb_resp_valid (resp_valid),
    .glb2csb_resp_pd    (resp_pd),
    .done_pulse         (pulse),
    .done_mask          (mask_o),
    .core_intr          (intr)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: register contents as plain integers plus the one request in flight.
  bit          m_pend;
  logic [62:0] m_req;
  logic [31:0] m_status;
  logic [31:0] m_mask;
  bit          e_vld;
  logic [33:0] e_pd;
  bit          e_intr;

  function automatic void model_reset();
    m_pend   = 1'b0;
    m_req    = '0;
    m_status = 32'h0;
    m_mask   = 32'h0000_FFFF;
    e_vld    = 1'b0;
    e_pd     = '0;
    e_intr   = 1'b0;
  endfunction

  function automatic void model_edge(input bit vld, input logic [62:0] pd, input logic [15:0] p);
    logic [31:0] w1c, setv, newmask, rd, wd;
    logic [21:0] a;
    bit wr, np, hit;
    logic [3:0] be;
    w1c = 0; setv = 0; newmask = m_mask; e_vld = 1'b0;
    if (m_pend) begin
      a = m_req[21:0]; wd = m_req[53:22]; wr = m_req[54]; np = m_req[55]; be = m_req[60:57];
      hit = (a[21:10] == 12'h000) && (a[9:0] < 4);
      rd = 0;
      if (hit && !wr) begin
        if (a[9:0] == 0) rd = 32'h0002_0000;
        if (a[9:0] == 1) rd = m_mask;
        if (a[9:0] == 3) rd = m_status;
      end
      if (hit && wr) begin
        if (a[9:0] == 1)
          for (int k = 0; k < 4; k++) if (be[k]) newmask[8*k +: 8] = wd[8*k +: 8];
        if (a[9:0] == 2) setv = wd;
        if (a[9:0] == 3) w1c = wd;
      end
      if (!wr || np) begin
        e_vld = 1'b1;
        e_pd  = {wr, ERR_EN & !hit, wr ? 32'h0 : rd};
      end
    end
    m_mask   = newmask & 32'h0000_FFFF;
    m_status = ((m_status & ~w1c) | {16'h0, p} | setv) & 32'h0000_FFFF;
    e_intr   = (m_status & ~m_mask) != 0;
    m_pend   = vld;
    m_req    = pd;
  endfunction

  function automatic logic [62:0] mk(input logic [21:0] a, input logic [31:0] d,
                                     input bit wr, input bit np, input logic [3:0] be);
    return {2'b00, be, 1'b0, np, wr, d, a};
  endfunction

  function automatic logic [62:0] rdw(input logic [9:0] w);
    return mk({12'h000, w}, 32'h0, 1'b0, 1'b0, 4'hF);
  endfunction

  // Called at a negedge: check outputs against the model, drive the next cycle's inputs.
  task automatic step(input bit vld, input logic [62:0] pd, input logic [15:0] p);
    chk("resp_valid", {63'h0, resp_valid}, {63'h0, e_vld});
    if (e_vld) chk("resp_pd", {30'h0, resp_pd}, {30'h0, e_pd});
    chk("core_intr", {63'h0, intr}, {63'h0, e_intr});
    chk("done_mask", {48'h0, mask_o}, {32'h0, m_mask});
    chk("prdy", {63'h0, prdy}, 64'h1);
    pvld = vld; req_pd = pd; pulse = p;
    model_edge(vld, pd, p);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0);
  endtask

  initial begin
    logic [21:0] a;
    logic [62:0] pd;
    rstn = 1'b0; pvld = 1'b0; req_pd = '0; pulse = '0;
    model_reset();
    #22 rstn = 1'b1;
    @(negedge clk);
    chk("rst_resp_pd", {30'h0, resp_pd}, 64'h0);
    chk("rst_resp_vld", {63'h0, resp_valid}, 64'h0);

    // Version and mask reset readback.
    step(1'b1, rdw(10'd0), '0); idle();
    chk("ver_vld", {63'h0, resp_valid}, 64'h1);
    chk("ver_pd", {30'h0, resp_pd}, 64'h0_0002_0000);
    step(1'b1, rdw(10'd1), '0); idle();
    chk("mask_rst_pd", {30'h0, resp_pd}, 64'h0_0000_FFFF);

    // Byte-lane mask write, nposted.
    step(1'b1, mk(22'd1, 32'h0, 1'b1, 1'b1, 4'b0001), '0); idle();
    chk("wr_resp_pd", {30'h0, resp_pd}, 64'h2_0000_0000);
    step(1'b1, rdw(10'd1), '0); idle();
    chk("mask_lane_pd", {30'h0, resp_pd}, 64'h0_0000_FF00);

    // Pulse -> interrupt, read, W1C.
    step(1'b0, '0, 16'h0008);
    chk("intr_pulse", {63'h0, intr}, 64'h1);
    step(1'b1, rdw(10'd3), '0); idle();
    chk("status_8", {30'h0, resp_pd}, 64'h0_0000_0008);
    step(1'b1, mk(22'd3, 32'h8, 1'b1, 1'b1, 4'h0), '0); idle();
    chk("intr_w1c", {63'h0, intr}, 64'h0);

    // Mask bit 0 only; pulse and W1C of bit 5 collide; SET bit 0.
    step(1'b1, mk(22'd1, 32'h0000_FF01, 1'b1, 1'b0, 4'hF), '0);
    step(1'b1, mk(22'd3, 32'h20, 1'b1, 1'b0, 4'h0), '0);
    step(1'b0, '0, 16'h0020);
    chk("set_dom_intr", {63'h0, intr}, 64'h1);
    step(1'b1, mk(22'd2, 32'h1, 1'b1, 1'b0, 4'h0), '0); idle();
    step(1'b1, rdw(10'd3), '0); idle();
    chk("status_21", {30'h0, resp_pd}, 64'h0_0000_0021);
    step(1'b1, mk(22'd3, 32'h20, 1'b1, 1'b0, 4'h0), '0); idle();
    chk("masked_bit0", {63'h0, intr}, 64'h0);

    // Posted write then back-to-back reads.
    step(1'b1, mk(22'd3, 32'h1, 1'b1, 1'b0, 4'h0), '0);
    step(1'b1, rdw(10'd3), '0);
    chk("posted_silent", {63'h0, resp_valid}, 64'h0);
    step(1'b1, rdw(10'd1), '0);
    chk("b2b_vld0", {63'h0, resp_valid}, 64'h1);
    chk("b2b_pd0", {30'h0, resp_pd}, 64'h0);
    idle();
    chk("b2b_vld1", {63'h0, resp_valid}, 64'h1);
    chk("b2b_pd1", {30'h0, resp_pd}, 64'h0_0000_FF01);

    // Base-address miss.
    step(1'b1, mk(22'h400, 32'h0, 1'b0, 1'b0, 4'hF), '0); idle();
    chk("miss_pd", {30'h0, resp_pd}, {30'h0, 1'b0, ERR_EN, 32'h0});

    // Reset between accept and response.
    step(1'b1, rdw(10'd0), 16'h0100);
    pvld = 1'b0; pulse = '0;
    rstn = 1'b0; #2 rstn = 1'b1;
    model_reset();
    chk("rst_mid_status_intr", {63'h0, intr}, 64'h0);
    idle();
    chk("rst_mid_no_resp", {63'h0, resp_valid}, 64'h0);
    idle();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) a = 22'($urandom);
      else a = {12'h000, 10'($urandom_range(0, 5))};
      pd = mk(a, $urandom, 1'($urandom), 1'($urandom), 4'($urandom));
      pd[62:61] = 2'($urandom);
      pd[56] = 1'($urandom);
      step($urandom_range(0, 9) < 7, pd, 16'($urandom & $urandom & $urandom));
    end
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
